// File: rtl/gps_carr_pkg.sv
// Shared types and constants for the GPS carrier tracking loop filter.
// Holds the update FSM encoding, datapath widths and saturation limits.
package gps_carr_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DISC = 3'd1,
        MUL1 = 3'd2,
        MUL2 = 3'd3,
        SUM  = 3'd4,
        OUT  = 3'd5
    } state_t;

    localparam int IQ_W    = 32;
    localparam int PROD_W  = 48;
    localparam int INTEG_W = 64;
    localparam int FREQ_W  = 62;
    localparam int GAIN_W  = 16;

    localparam logic signed [IQ_W-1:0]    IQ_MAX    = 32'sh7FFF_FFFF;
    localparam logic signed [IQ_W-1:0]    IQ_MIN    = 32'sh8000_0000;
    localparam logic        [INTEG_W-1:0] INTEG_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic        [FREQ_W-1:0]  FREQ_MAX  = {FREQ_W{1'b1}};

endpackage

// File: rtl/gps_carr_loop_sat_add.sv
// Signed saturating adder; the result is clamped symmetrically to +/-LIMIT.
// Computed one bit wider so the true sum is never lost before clamping.
module gps_sat_add #(
    parameter int           W     = 64,
    parameter logic [W-1:0] LIMIT = {1'b0, {(W-1){1'b1}}}
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum
);

    localparam logic signed [W:0] MAX = {1'b0, LIMIT};
    localparam logic signed [W:0] MIN = -MAX;

    logic signed [W:0] full;

    always_comb begin
        full = {a[W-1], a} + {b[W-1], b};
        if (full > MAX) begin
            sum = MAX[W-1:0];
        end else if (full < MIN) begin
            sum = MIN[W-1:0];
        end else begin
            sum = full[W-1:0];
        end
    end

endmodule

// File: rtl/gps_carr_loop.sv
// Second-order Costas carrier loop filter: discriminator, shared-multiplier PI
// filter and NCO frequency word update, sequenced one step per clock.
module gps_carr_loop
    import gps_carr_pkg::*;
#(
    parameter int SHIFT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iq_valid,
    input  logic [IQ_W-1:0]   i_acc,
    input  logic [IQ_W-1:0]   q_acc,
    input  logic [FREQ_W-1:0] f_base,
    input  logic [GAIN_W-1:0] k1,
    input  logic [GAIN_W-1:0] k2,
    input  logic              loop_en,
    output logic [FREQ_W-1:0] f_control,
    output logic              f_valid,
    output logic              busy,
    output logic              iq_drop
);

    state_t state;
    state_t state_nx;

    logic                      i_neg_p0;
    logic signed [IQ_W-1:0]    q_p0;
    logic signed [IQ_W-1:0]    d_p1;
    logic signed [PROD_W-1:0]  prop_p2;
    logic        [FREQ_W-1:0]  f_next_p4;

    logic        [GAIN_W-1:0]  k_sel;
    logic signed [PROD_W-1:0]  mul_a;
    logic signed [PROD_W-1:0]  mul_b;
    logic signed [PROD_W-1:0]  mul_y;
    logic signed [INTEG_W-1:0] mul_ext;
    logic signed [INTEG_W-1:0] prop_ext;
    logic signed [INTEG_W-1:0] integ;
    logic signed [INTEG_W-1:0] integ_sum;
    logic signed [INTEG_W-1:0] s_sum;
    logic signed [INTEG_W-1:0] s_shift;
    logic signed [FREQ_W+3:0]  f_wide;

    function automatic logic signed [IQ_W-1:0] neg_sat(input logic signed [IQ_W-1:0] x);
        return (x == IQ_MIN) ? IQ_MAX : -x;
    endfunction

    function automatic logic [FREQ_W-1:0] clamp_freq(input logic signed [FREQ_W+3:0] x);
        if (x < 0) begin
            return '0;
        end
        if (x > $signed({4'b0000, FREQ_MAX})) begin
            return FREQ_MAX;
        end
        return x[FREQ_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        unique case (state)
            IDLE:    if (iq_valid) state_nx = DISC;
            DISC:    state_nx = MUL1;
            MUL1:    state_nx = MUL2;
            MUL2:    state_nx = SUM;
            SUM:     state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One multiplier: k1 drives it in MUL1, k2 in MUL2; gains are zero-extended.
    assign k_sel    = (state == MUL2) ? k2 : k1;
    assign mul_a    = PROD_W'(d_p1);
    assign mul_b    = $signed({{(PROD_W-GAIN_W){1'b0}}, k_sel});
    assign mul_y    = mul_a * mul_b;
    assign mul_ext  = INTEG_W'(mul_y);
    assign prop_ext = INTEG_W'(prop_p2);

    gps_sat_add #(.W(INTEG_W), .LIMIT(INTEG_MAX)) u_integ_add (
        .a   (integ),
        .b   (mul_ext),
        .sum (integ_sum)
    );

    gps_sat_add #(.W(INTEG_W), .LIMIT(INTEG_MAX)) u_sum_add (
        .a   (integ),
        .b   (prop_ext),
        .sum (s_sum)
    );

    assign s_shift = s_sum >>> SHIFT;
    assign f_wide  = $signed({4'b0000, f_base}) + (FREQ_W+4)'(s_shift);

    always_ff @(posedge clk) begin
        unique case (state)
            // p0: capture; only the sign of I matters to the discriminator
            IDLE: begin
                if (iq_valid) begin
                    i_neg_p0 <= i_acc[IQ_W-1];
                    q_p0     <= $signed(q_acc);
                end
            end
            // p1: Costas discriminator
            DISC: d_p1 <= i_neg_p0 ? neg_sat(q_p0) : q_p0;
            // p2: proportional term
            MUL1: prop_p2 <= mul_y;
            // p4: frequency word, f_base sampled here
            SUM:  f_next_p4 <= clamp_freq(f_wide);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            integ     <= '0;
            f_control <= f_base;
            f_valid   <= 1'b0;
            iq_drop   <= 1'b0;
        end else begin
            f_valid <= (state == OUT);
            if (state == OUT) begin
                f_control <= f_next_p4;
            end
            if (iq_valid && state != IDLE) begin
                iq_drop <= 1'b1;
            end
            if (!loop_en) begin
                integ <= '0;
            end else if (state == MUL2) begin
                integ <= integ_sum;
            end
        end
    end

endmodule

// File: tb/tb_gps_carr_loop.sv
// Scoreboard bench for gps_carr_loop: a driver issues updates and queues the
// expected frequency words, a monitor checks every cycle against them.
module tb_gps_carr_loop;

    localparam int SHIFT = 0;
    localparam logic signed [127:0] LIM  = (128'sd1 <<< 63) - 128'sd1;
    localparam logic signed [127:0] FMAX = (128'sd1 <<< 62) - 128'sd1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iq_valid = 1'b0;
    logic [31:0] i_acc = '0;
    logic [31:0] q_acc = '0;
    logic [61:0] f_base = '0;
    logic [15:0] k1 = '0;
    logic [15:0] k2 = '0;
    logic        loop_en = 1'b0;
    logic [61:0] f_control;
    logic        f_valid;
    logic        busy;
    logic        iq_drop;

    gps_carr_loop #(.SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .iq_valid  (iq_valid),
        .i_acc     (i_acc),
        .q_acc     (q_acc),
        .f_base    (f_base),
        .k1        (k1),
        .k2        (k2),
        .loop_en   (loop_en),
        .f_control (f_control),
        .f_valid   (f_valid),
        .busy      (busy),
        .iq_drop   (iq_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [61:0] f;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   done = 1'b0;
    logic signed [127:0] integ_m = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic signed [127:0] sat(input logic signed [127:0] x);
        if (x > LIM) return LIM;
        if (x < -LIM) return -LIM;
        return x;
    endfunction

    // Reference filter in wide exact arithmetic; integ_m is the model's integrator.
    function automatic logic [61:0] ref_update(input logic [31:0] i, input logic [31:0] q,
                                               input logic [61:0] fb, input logic [15:0] g1,
                                               input logic [15:0] g2, input logic en);
        logic signed [127:0] d, prop, s, f;
        if ($signed(i) >= 0) d = $signed(q);
        else if (q == 32'h8000_0000) d = 128'sd2147483647;
        else d = -$signed(q);
        prop = d * $signed({1'b0, g1});
        if (en) integ_m = sat(integ_m + d * $signed({1'b0, g2}));
        else integ_m = '0;
        s = sat(integ_m + prop);
        f = $signed({66'd0, fb}) + (s >>> SHIFT);
        if (f < 0) f = '0;
        else if (f > FMAX) f = FMAX;
        return f[61:0];
    endfunction

    task automatic upd(input logic [31:0] i, input logic [31:0] q, input logic [61:0] fb,
                       input logic [15:0] g1, input logic [15:0] g2, input logic en);
        logic [61:0] fx;
        @(negedge clk);
        i_acc = i; q_acc = q; f_base = fb; k1 = g1; k2 = g2; loop_en = en;
        iq_valid = 1'b1;
        fx = ref_update(i, q, fb, g1, g2, en);
        sbq.push_back('{fx, cyc + 6});
        @(negedge clk);
        iq_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        integ_m = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [63:0] r64;
        logic [61:0] fb;
        logic [61:0] fx;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        upd(32'd5, 32'd7, 62'd1000, 16'd1, 16'd0, 1'b1);
        upd(-32'sd5, 32'd7, 62'd1000, 16'd1, 16'd0, 1'b1);

        do_reset();
        repeat (3) upd(32'd1, 32'd10, 62'd1000, 16'd0, 16'd2, 1'b1);

        do_reset();
        upd(-32'sd1, 32'h8000_0000, 62'd1000, 16'd1, 16'd0, 1'b1);
        upd(32'd1, -32'sd50, 62'd0, 16'd1, 16'd0, 1'b1);

        // overlapping request two cycles after acceptance
        @(negedge clk);
        i_acc = 32'd5; q_acc = 32'd7; f_base = 62'd1000; k1 = 16'd1; k2 = 16'd0; loop_en = 1'b1;
        iq_valid = 1'b1;
        fx = ref_update(32'd5, 32'd7, 62'd1000, 16'd1, 16'd0, 1'b1);
        sbq.push_back('{fx, cyc + 6});
        @(negedge clk);
        iq_valid = 1'b0;
        @(negedge clk);
        q_acc = 32'd100;
        iq_valid = 1'b1;
        @(negedge clk);
        iq_valid = 1'b0;
        repeat (3) @(negedge clk);

        // reset three cycles into an update with a loaded integrator
        do_reset();
        upd(32'd1, 32'd10, 62'd1000, 16'd0, 16'd2, 1'b1);
        @(negedge clk);
        i_acc = 32'd1; q_acc = 32'd10; iq_valid = 1'b1;
        @(negedge clk);
        iq_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        integ_m = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        upd(32'd1, 32'd10, 62'd1000, 16'd0, 16'd2, 1'b1);

        repeat (3) upd(32'd1, 32'd10, 62'd1000, 16'd1, 16'd2, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r64 = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       fb = 62'($urandom_range(0, 1000));
                1:       fb = 62'(FMAX) - 62'($urandom_range(0, 1000));
                default: fb = r64[61:0];
            endcase
            upd($urandom, ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom, fb,
                16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                $urandom_range(0, 3) != 0);
        end

        repeat (3) @(negedge clk);
        done = 1'b1;
    end

    // Monitor: spec-level busy/drop tracking plus scoreboard comparison.
    int          cnt = 0;
    bit          drop_m = 1'b0;
    logic [61:0] hold_ref = '0;
    logic        s_rst;
    logic        s_iqv;

    always begin
        @(posedge clk);
        cyc++;
        s_rst = rst;
        s_iqv = iq_valid;
        if (!s_rst) begin
            cnt = 0;
            drop_m = 1'b0;
        end else begin
            if (s_iqv && cnt > 0) drop_m = 1'b1;
            if (cnt > 0) cnt--;
            else if (s_iqv) cnt = 5;
        end
        #2;
        if (!s_rst) begin
            chk("reset_f_control", 64'(f_control), 64'(f_base));
            chk("reset_f_valid", 64'(f_valid), 64'd0);
            chk("reset_busy", 64'(busy), 64'd0);
            chk("reset_iq_drop", 64'(iq_drop), 64'd0);
            hold_ref = f_base;
        end else begin
            chk("busy", 64'(busy), 64'(cnt > 0));
            chk("iq_drop", 64'(iq_drop), 64'(drop_m));
            if (f_valid) begin
                if (sbq.size() == 0) begin
                    chk("f_valid_unexpected", 64'(f_valid), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("f_control", 64'(f_control), 64'(e.f));
                    chk("f_valid_cycle", 64'(cyc), 64'(e.cyc));
                    hold_ref = e.f;
                end
            end else begin
                chk("f_control_hold", 64'(f_control), 64'(hold_ref));
            end
        end
        if (done) begin
            chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gps_carr_loop.md
GPS_CARR_LOOP -- requirements
Module: gps_carr_loop

Interface
REQ-001 The block SHALL have parameter SHIFT, default 16, giving the right-shift applied to the filter sum before it is added to f_base.
REQ-002 The block SHALL have these ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-low.
- iq_valid, in, 1: I/Q accumulation result presented this cycle.
- i_acc, in, 32: signed prompt in-phase accumulation.
- q_acc, in, 32: signed prompt quadrature accumulation.
- f_base, in, 62: unsigned nominal carrier frequency word (IF plus Doppler seed).
- k1, in, 16: unsigned proportional gain.
- k2, in, 16: unsigned integral gain.
- loop_en, in, 1: closed-loop enable.
- f_control, out, 62: unsigned frequency word driven to the carrier NCO.
- f_valid, out, 1: one-cycle pulse when f_control updates.
- busy, out, 1: high while an update is in progress.
- iq_drop, out, 1: sticky flag, set when iq_valid arrives while busy.

Function
REQ-003 The FSM SHALL have states IDLE, DISC, MUL1, MUL2, SUM and OUT, each state lasting one cycle.
REQ-004 In IDLE, iq_valid=1 SHALL capture i_acc and q_acc and move to DISC; busy SHALL be high in every state except IDLE.
REQ-005 DISC SHALL compute the Costas discriminator d = q_acc if i_acc >= 0, else -q_acc, as a 32-bit signed value; negating -2^31 SHALL saturate to 2^31-1.
REQ-006 MUL1 SHALL compute prop = d*k1, a 48-bit signed value, on one shared multiplier.
REQ-007 MUL2 SHALL compute d*k2 on the same multiplier and add it, sign-extended, into integ, a 64-bit signed accumulator that saturates at ±(2^63-1) bounds.
REQ-008 SUM SHALL compute s = sat64(integ + sext(prop)), then f_next = f_base + (s >>> SHIFT), clamped to [0, 2^62-1].
REQ-009 OUT SHALL register f_next into f_control, pulse f_valid for exactly one cycle, and return to IDLE.
REQ-010 Latency: iq_valid accepted at cycle 0 SHALL produce f_valid at cycle 5, and the next iq_valid SHALL be accepted no earlier than cycle 6.
REQ-011 iq_valid while busy SHALL be ignored (the update is not restarted) and SHALL set iq_drop; iq_drop SHALL clear only on reset.
REQ-012 When loop_en=0, integ SHALL be held at 0 and updates SHALL still run, producing f_control = f_base + (prop >>> SHIFT) with the same timing.
REQ-013 A change of f_base, k1 or k2 during an update SHALL take effect in the state that samples it (k1 in MUL1, k2 in MUL2, f_base in SUM); no snapshot is taken.
REQ-014 f_control SHALL hold its value between f_valid pulses.

Reset
REQ-015 With rst=0 at a clock edge: state returns to IDLE; integ=0; f_valid=0; busy=0; iq_drop=0; f_control loads f_base.
REQ-016 Reset mid-update SHALL abort the update, and no f_valid SHALL be issued for it.

Structure
REQ-017 Package gps_carr_pkg SHALL hold:
- the FSM state enum;
- width constants: 32 for I/Q, 48 for product, 64 for integrator, 62 for frequency word;
- the saturation limit constants.
REQ-018 Sub-module gps_sat_add (parameterised-width signed saturating adder) SHALL be used for the integrator update and for the SUM step.
REQ-019 A single multiplier instance SHALL be time-shared between MUL1 and MUL2.

Verification
REQ-020 Proportional path, SHIFT=0, k1=1, k2=0, f_base=1000:
- I=5, Q=7 -> f_control=1007 with f_valid at cycle 5.
- I=-5, Q=7 -> f_control=993.
REQ-021 Integral path, SHIFT=0, k1=0, k2=2, f_base=1000: three updates with I=1, Q=10 -> f_control=1020, then 1040, then 1060.
REQ-022 Saturation, SHIFT=0, k1=1, k2=0: I=-1, Q=-2^31 -> d=2^31-1 and f_control=f_base+2^31-1. With f_base=0 and I=1, Q=-50 -> f_control clamps to 0.
REQ-023 Overlap: second iq_valid at cycle 2 -> ignored, iq_drop=1, exactly one f_valid pulse at cycle 5.
REQ-024 Reset mid-op: rst=0 at cycle 3 -> busy=0, integ=0, f_control=f_base, and no f_valid at cycle 5.
REQ-025 loop_en=0 with k2=2 over several updates -> integ stays 0 and f_control reflects the proportional term only.
